// File: rtl/gat_pkg.sv
// Shared constants and types for the GAT accelerator datapath.
package gat_pkg;

  localparam int unsigned NEW_FEATURE_WIDTH  = 32;
  localparam int unsigned NUM_FEATURE_OUT    = 16;
  localparam int unsigned NUM_SUBGRAPHS      = 2708;
  localparam int unsigned NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT;
  localparam int unsigned NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH);

  // Readout sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } gat_out_state_e;

  // One output-stream beat as held in the output FIFO.
  typedef struct packed {
    logic [NEW_FEATURE_WIDTH-1:0] tdata;
    logic                         tuser;
    logic                         tlast;
  } gat_feat_beat_t;

endpackage

// File: rtl/gat_fwft_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// The head entry is visible on rdata whenever valid is high; rdata reads as zero when empty.
// Push and pop may coincide even when full.
module gat_fwft_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             full, push_eff, pop_eff;

  assign valid    = (count_q != '0);
  assign full     = (count_q == CntW'(DEPTH));
  assign pop_eff  = pop && valid;
  assign push_eff = push && (!full || pop_eff);
  assign rdata    = valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop_eff) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      unique case ({push_eff, pop_eff})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Upstream must never push into a full FIFO without a simultaneous pop.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/gat_feat_stream_out.sv
// Feature readout: sweeps the new-feature BRAM port B and streams every word on AXI4-Stream.
// A credit counter bounds issued-but-unconsumed reads to the FIFO depth, so the read pipeline
// can never overrun the output FIFO under back-pressure.
module gat_feat_stream_out #(
  parameter int unsigned NUM_FEATURE_OUT    = gat_pkg::NUM_FEATURE_OUT,
  parameter int unsigned NUM_SUBGRAPHS      = gat_pkg::NUM_SUBGRAPHS,
  parameter int unsigned NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  parameter int unsigned NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int unsigned BRAM_RD_LAT        = 2,
  parameter int unsigned FIFO_DEPTH         = BRAM_RD_LAT + 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  gat_ready,
  input  logic                                  start,
  output logic [NEW_FEATURE_ADDR_W+1:0]         feat_bram_addrb,
  input  logic [gat_pkg::NEW_FEATURE_WIDTH-1:0] feat_bram_dout,
  output logic [gat_pkg::NEW_FEATURE_WIDTH-1:0] m_axis_tdata,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic                                  m_axis_tuser,
  output logic                                  m_axis_tlast,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  start_err
);

  import gat_pkg::*;

  localparam int unsigned AW   = NEW_FEATURE_ADDR_W;
  localparam int unsigned RowW = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BeatW = $bits(gat_feat_beat_t);
  localparam logic [CntW:0] CreditLimit = (CntW + 1)'(FIFO_DEPTH);

  gat_out_state_e       state_q;
  logic [AW-1:0]        rd_idx_q, out_cnt_q;
  logic [RowW-1:0]      row_cnt_q;
  logic                 busy_q, done_q, start_err_q;
  logic [BRAM_RD_LAT-1:0] dl_valid_q, dl_user_q, dl_last_q;
  logic [CntW-1:0]      inflight, fifo_count;
  logic [CntW:0]        credit_used;
  logic                 issue, tag_user, tag_last, beat_xfer, fifo_push, fifo_valid;
  gat_feat_beat_t       push_beat, head_beat;
  logic [BeatW-1:0]     head_bits;

  // Reads in the delay line are those issued but not yet returned.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < BRAM_RD_LAT; i++) begin
      inflight = inflight + CntW'(dl_valid_q[i]);
    end
  end

  // Issue decision and the tags that travel with each read.
  always_comb begin
    credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    issue       = (state_q == StRun) && (credit_used < CreditLimit);
    tag_user    = (row_cnt_q == RowW'(NUM_FEATURE_OUT - 1));
    tag_last    = (rd_idx_q == AW'(NEW_FEATURE_DEPTH - 1));
  end

  // Delay line aligning tags with BRAM read data; reset discards reads in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dl_valid_q <= '0;
      dl_user_q  <= '0;
      dl_last_q  <= '0;
    end else begin
      dl_valid_q[0] <= issue;
      dl_user_q[0]  <= issue && tag_user;
      dl_last_q[0]  <= issue && tag_last;
      for (int i = 1; i < BRAM_RD_LAT; i++) begin
        dl_valid_q[i] <= dl_valid_q[i-1];
        dl_user_q[i]  <= dl_user_q[i-1];
        dl_last_q[i]  <= dl_last_q[i-1];
      end
    end
  end

  assign fifo_push       = dl_valid_q[BRAM_RD_LAT-1];
  assign push_beat.tdata = feat_bram_dout;
  assign push_beat.tuser = dl_user_q[BRAM_RD_LAT-1];
  assign push_beat.tlast = dl_last_q[BRAM_RD_LAT-1];

  gat_fwft_fifo #(
    .WIDTH (BeatW),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (push_beat),
    .pop   (beat_xfer),
    .rdata (head_bits),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  assign head_beat       = head_bits;
  assign m_axis_tvalid   = fifo_valid;
  assign m_axis_tdata    = head_beat.tdata;
  assign m_axis_tuser    = head_beat.tuser;
  assign m_axis_tlast    = head_beat.tlast;
  assign beat_xfer       = m_axis_tvalid && m_axis_tready;
  // rd_idx holds at the final index after the last issue, so addrb never leaves the frame.
  assign feat_bram_addrb = {rd_idx_q, 2'b00};
  assign busy            = busy_q;
  assign done            = done_q;
  assign start_err       = start_err_q;

  // Readout sequencer with registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rd_idx_q    <= '0;
      row_cnt_q   <= '0;
      out_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (beat_xfer && !m_axis_tlast) begin
        out_cnt_q <= out_cnt_q + AW'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (start && gat_ready) begin
            state_q     <= StRun;
            busy_q      <= 1'b1;
            rd_idx_q    <= '0;
            row_cnt_q   <= '0;
            out_cnt_q   <= '0;
            start_err_q <= 1'b0;
          end else if (start) begin
            start_err_q <= 1'b1;
          end
        end
        StRun: begin
          if (start) begin
            start_err_q <= 1'b1;
          end
          if (issue) begin
            row_cnt_q <= tag_user ? '0 : row_cnt_q + RowW'(1);
            if (tag_last) begin
              state_q <= StDrain;
            end else begin
              rd_idx_q <= rd_idx_q + AW'(1);
            end
          end
        end
        StDrain: begin
          if (start) begin
            start_err_q <= 1'b1;
          end
          if (beat_xfer && m_axis_tlast) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          if (start) begin
            start_err_q <= 1'b1;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The tlast beat must be exactly the last word of the frame.
  assert property (@(posedge clk) disable iff (!rst_n)
    (beat_xfer && m_axis_tlast) |-> (out_cnt_q == AW'(NEW_FEATURE_DEPTH - 1)));

endmodule
